// File: rtl/invaders_dl_loader_if.sv
// hps_io download stream bundle: hps_io drives it (master), the loader consumes it (slave).
interface invaders_dl_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index
  );

  modport slave (
    input ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index
  );
endinterface

// File: rtl/invaders_dl_loader.sv
// Routes the hps_io download stream to ROM, machine-select and DIP registers,
// and generates the core reset and load status around ROM/machine loads.
module invaders_dl_loader #(
  parameter int unsigned ROM_AW     = 16,
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  invaders_dl_loader_if.slave  ioctl,
  output logic                 rom_wr,
  output logic [ROM_AW-1:0]    rom_addr,
  output logic [7:0]           rom_data,
  output logic [7:0]           mod,
  output logic [63:0]          dip,
  output logic                 core_reset,
  output logic                 dl_busy,
  output logic                 dl_done,
  output logic [ROM_AW:0]      rom_len,
  output logic                 rom_ovf
);
  localparam int unsigned   CW       = $clog2(SETTLE_CYC + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYC);

  typedef enum logic [1:0] {IDLE, LOAD_ROM, LOAD_MOD, SETTLE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          dl_prev_q;
  logic          stale_q;
  logic          from_load_q;

  logic            dl_rise;
  logic            dl_fall;
  logic            start_rom;
  logic            start_mod;
  logic            addr_in_rom;
  logic            dip_hit;
  logic [ROM_AW:0] addr_p1;

  always_comb begin
    // stale_q masks a download already active at reset release until it drops
    dl_rise     = ioctl.ioctl_download & ~dl_prev_q & ~stale_q;
    dl_fall     = ~ioctl.ioctl_download & dl_prev_q;
    start_rom   = dl_rise && (ioctl.ioctl_index == 8'd0);
    start_mod   = dl_rise && (ioctl.ioctl_index == 8'd1);
    addr_in_rom = (ioctl.ioctl_addr[24:ROM_AW] == '0);
    addr_p1     = {1'b0, ioctl.ioctl_addr[ROM_AW-1:0]} + (ROM_AW+1)'(1);
    dip_hit     = ioctl.ioctl_wr && (ioctl.ioctl_index == 8'd254) &&
                  (ioctl.ioctl_addr[24:3] == '0);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= SETTLE;
      cnt_q       <= CNT_INIT;
      dl_prev_q   <= 1'b0;
      stale_q     <= 1'b1;
      from_load_q <= 1'b0;
      rom_wr      <= 1'b0;
      rom_addr    <= '0;
      rom_data    <= '0;
      mod         <= '0;
      dip         <= '0;
      core_reset  <= 1'b1;
      dl_busy     <= 1'b1;
      dl_done     <= 1'b0;
      rom_len     <= '0;
      rom_ovf     <= 1'b0;
    end else begin
      dl_prev_q <= ioctl.ioctl_download;
      if (!ioctl.ioctl_download) stale_q <= 1'b0;
      rom_wr  <= 1'b0;
      dl_done <= 1'b0;

      if (dip_hit) dip[{ioctl.ioctl_addr[2:0], 3'b000} +: 8] <= ioctl.ioctl_dout;

      unique case (state_q)
        IDLE, SETTLE: begin
          if (start_rom) begin
            state_q    <= LOAD_ROM;
            rom_len    <= '0;
            rom_ovf    <= 1'b0;
            core_reset <= 1'b1;
            dl_busy    <= 1'b1;
          end else if (start_mod) begin
            state_q    <= LOAD_MOD;
            core_reset <= 1'b1;
            dl_busy    <= 1'b1;
          end else if (state_q == SETTLE) begin
            if (cnt_q == CW'(1)) begin
              state_q    <= IDLE;
              core_reset <= 1'b0;
              dl_busy    <= 1'b0;
              dl_done    <= from_load_q;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
        end

        LOAD_ROM: begin
          // the write is honoured even on the fall cycle
          if (ioctl.ioctl_wr) begin
            if (addr_in_rom) begin
              rom_wr   <= 1'b1;
              rom_addr <= ioctl.ioctl_addr[ROM_AW-1:0];
              rom_data <= ioctl.ioctl_dout;
              if (addr_p1 > rom_len) rom_len <= addr_p1;
            end else begin
              rom_ovf <= 1'b1;
            end
          end
          if (dl_fall) begin
            state_q     <= SETTLE;
            cnt_q       <= CNT_INIT;
            from_load_q <= 1'b1;
          end
        end

        LOAD_MOD: begin
          if (ioctl.ioctl_wr) mod <= ioctl.ioctl_dout;
          if (dl_fall) begin
            state_q     <= SETTLE;
            cnt_q       <= CNT_INIT;
            from_load_q <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule
